// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared defaults and slice-width derivation for pipelined_adder
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  // WIDTH must divide evenly by STAGES; every stage handles one equal slice.
  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational SW-bit ripple-carry adder used once per pipeline stage
module adder_slice #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  logic [SW:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SW; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[SW];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep carry-pipelined adder/subtractor with global valid/ready stall
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  localparam int SW = slice_width(WIDTH, STAGES);
  localparam int L  = STAGES - 1;

  // Row k holds what stage k sees/stores; column j is slice j of the operand or sum.
  // Stage k keeps operand slices j > k (not yet added) and sum slices j <= k.
  logic [SW-1:0] in_a [STAGES][STAGES];
  logic [SW-1:0] in_b [STAGES][STAGES];
  logic [SW-1:0] in_s [STAGES][STAGES];
  logic [SW-1:0] a_q  [STAGES][STAGES];
  logic [SW-1:0] b_q  [STAGES][STAGES];
  logic [SW-1:0] s_q  [STAGES][STAGES];

  logic [STAGES-1:0] in_v;
  logic [STAGES-1:0] in_c;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cry_q;
  logic [SW-1:0]     slice_s [STAGES];
  logic [STAGES-1:0] slice_co;

  logic             adv;
  logic             ovf_q;
  logic             ovf_next;
  logic [WIDTH-1:0] b_eff;

  assign adv      = ~vld_q[L] | Out_Ready;
  assign In_Ready = adv;

  // Subtract is A + ~B + 1, so the inversion and forced carry happen before stage 0.
  assign b_eff   = Sub ? ~B : B;
  assign in_v[0] = In_Valid;
  assign in_c[0] = Sub | Cin;

  for (genvar j = 0; j < STAGES; j++) begin : g_src0
    assign in_a[0][j] = A[j*SW +: SW];
    assign in_b[0][j] = b_eff[j*SW +: SW];
    assign in_s[0][j] = '0;
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_link
    assign in_v[k] = vld_q[k-1];
    assign in_c[k] = cry_q[k-1];
    for (genvar j = 0; j < STAGES; j++) begin : g_col
      assign in_a[k][j] = a_q[k-1][j];
      assign in_b[k][j] = b_q[k-1][j];
      assign in_s[k][j] = s_q[k-1][j];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    adder_slice #(
      .SW(SW)
    ) u_slice (
      .a    (in_a[k][k]),
      .b    (in_b[k][k]),
      .cin  (in_c[k]),
      .sum  (slice_s[k]),
      .cout (slice_co[k])
    );
  end

  // Signed overflow only depends on the top slice, which the last stage adds.
  assign ovf_next = (in_a[L][L][SW-1] == in_b[L][L][SW-1]) &
                    (slice_s[L][SW-1] != in_a[L][L][SW-1]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_q <= '0;
      cry_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        for (int j = 0; j < STAGES; j++) begin
          a_q[k][j] <= '0;
          b_q[k][j] <= '0;
          s_q[k][j] <= '0;
        end
      end
    end else if (adv) begin
      vld_q <= in_v;
      cry_q <= slice_co;
      ovf_q <= ovf_next;
      for (int k = 0; k < STAGES; k++) begin
        for (int j = 0; j < STAGES; j++) begin
          if (j > k) begin
            a_q[k][j] <= in_a[k][j];
            b_q[k][j] <= in_b[k][j];
          end
          if (j < k) begin
            s_q[k][j] <= in_s[k][j];
          end else if (j == k) begin
            s_q[k][j] <= slice_s[k];
          end
        end
      end
    end
  end

  always_comb begin
    Sum = '0;
    for (int j = 0; j < STAGES; j++) begin
      Sum[j*SW +: SW] = s_q[L][j];
    end
  end

  assign Carry     = cry_q[L];
  assign Overflow  = ovf_q;
  assign Out_Valid = vld_q[L];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized and directed self-checking bench for pipelined_adder
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic [W-1:0] a, b, sum;
  logic cin, sub, in_valid, in_ready, carry, overflow, out_valid, out_ready;

  logic [W-1:0] a1, b1, sum1;
  logic cin1, sub1, in_valid1, in_ready1, carry1, overflow1, out_valid1, out_ready1;

  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .Clk(clk), .Rst_n(rst_n), .A(a), .B(b), .Cin(cin), .Sub(sub),
    .In_Valid(in_valid), .In_Ready(in_ready), .Sum(sum), .Carry(carry),
    .Overflow(overflow), .Out_Valid(out_valid), .Out_Ready(out_ready)
  );

  pipelined_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .Sub(sub1),
    .In_Valid(in_valid1), .In_Ready(in_ready1), .Sum(sum1), .Carry(carry1),
    .Overflow(overflow1), .Out_Valid(out_valid1), .Out_Ready(out_ready1)
  );

  // {overflow, carry, sum} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] ye;
    logic [W:0]   t;
    logic         ov;
    ye = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    ov = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
    return {ov, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = '0; b = '0; cin = 0; sub = 0; in_valid = 0; out_ready = 0;
    a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; in_valid1 = 0; out_ready1 = 0;
    repeat (2) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_vec++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0000", sum); end
    n_vec++; if ({carry, overflow} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {carry, overflow}); end
    n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_s1: got %0b want 0", out_valid1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tbv [4];
    logic [W-1:0] es [4];
    logic         tsub [4];
    logic         ec [4];
    logic         eo [4];
    ta   = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    tbv  = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    tsub = '{1'b0, 1'b0, 1'b1, 1'b1};
    es   = '{16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    ec   = '{1'b1, 1'b0, 1'b0, 1'b1};
    eo   = '{1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      a = ta[v]; b = tbv[v]; sub = tsub[v]; cin = 1'b0; in_valid = 1'b1;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready: got %0b want 1", v, in_ready); end
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < S; c++) begin
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_early_valid c%0d: got %0b want 0", v, c, out_valid); end
        tick();
      end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_latency: got out_valid %0b want 1", v, out_valid); end
      n_vec++;
      if (sum !== es[v] || carry !== ec[v] || overflow !== eo[v]) begin
        n_err++;
        $display("FAIL dir%0d_result: got sum %h c %0b ov %0b want sum %h c %0b ov %0b",
                 v, sum, carry, overflow, es[v], ec[v], eo[v]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic         hold_v;
    logic [W+1:0] hold_d;
    logic [W+1:0] e;
    hold_v = 1'b0;
    hold_d = '0;
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      #1;
      n_vec++;
      if (in_ready !== (!out_valid || out_ready)) begin
        n_err++; $display("FAIL rnd_in_ready cyc%0d: got %0b want %0b", i, in_ready, (!out_valid || out_ready));
      end
      if (hold_v) begin
        n_vec++;
        if (out_valid !== 1'b1 || {overflow, carry, sum} !== hold_d) begin
          n_err++; $display("FAIL rnd_hold cyc%0d: got %h want %h", i, {overflow, carry, sum}, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious cyc%0d: got result %h want none", i, sum);
        end else begin
          e = exp_q.pop_front();
          if ({overflow, carry, sum} !== e) begin
            n_err++; $display("FAIL rnd_result cyc%0d: got %h want %h", i, {overflow, carry, sum}, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      hold_v = out_valid && !out_ready;
      hold_d = {overflow, carry, sum};
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({overflow, carry, sum} !== e) begin
          n_err++; $display("FAIL rnd_drain_result: got %h want %h", {overflow, carry, sum}, e);
        end
      end
      tick();
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_drain_timeout: got %0d left want 0", exp_q.size()); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_idle_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    int           sent;
    int           got;
    logic         stall;
    logic         hold_v;
    logic [W+1:0] hold_d;
    logic [W+1:0] e;
    sent = 0; got = 0; hold_v = 1'b0; hold_d = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      stall     = (cyc >= 5 && cyc < 8);
      out_ready = !stall;
      in_valid  = (sent < 8);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      #1;
      if (stall) begin
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_in_ready cyc%0d: got %0b want 0", cyc, in_ready); end
      end
      if (hold_v) begin
        n_vec++;
        if (out_valid !== 1'b1 || {overflow, carry, sum} !== hold_d) begin
          n_err++; $display("FAIL b2b_hold cyc%0d: got %h want %h", cyc, {overflow, carry, sum}, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_spurious cyc%0d: got %h want none", cyc, sum);
        end else begin
          e = exp_q.pop_front();
          got++;
          if ({overflow, carry, sum} !== e) begin
            n_err++; $display("FAIL b2b_result%0d: got %h want %h", got, {overflow, carry, sum}, e);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        sent++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = {overflow, carry, sum};
      tick();
    end
    in_valid = 1'b0;
    n_vec++; if (got != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", got); end
  endtask

  task automatic test_reset_in_flight();
    logic [W+1:0] e;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rif_pre_valid: got %0b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rif_async_valid: got %0b want 0", out_valid); end
    n_vec++; if ({overflow, carry, sum} !== '0) begin n_err++; $display("FAIL rif_async_data: got %h want 0", {overflow, carry, sum}); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rif_async_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rif_stale cyc%0d: got %0b want 0", i, out_valid); end
    end
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    e = model(a, b, cin, sub);
    tick();
    in_valid = 1'b0;
    repeat (S - 1) tick();
    n_vec++;
    if (out_valid !== 1'b1 || {overflow, carry, sum} !== e) begin
      n_err++; $display("FAIL rif_resume: got v%0b %h want v1 %h", out_valid, {overflow, carry, sum}, e);
    end
    tick();
  endtask

  task automatic test_single_stage();
    logic [W+1:0] e;
    out_ready1 = 1'b1;
    a1 = 16'h00FF; b1 = 16'h0000; cin1 = 1'b1; sub1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n_vec++;
    if (out_valid1 !== 1'b1 || sum1 !== 16'h0100 || carry1 !== 1'b0 || overflow1 !== 1'b0) begin
      n_err++; $display("FAIL s1_directed: got v%0b sum %h c%0b ov%0b want v1 sum 0100 c0 ov0",
                        out_valid1, sum1, carry1, overflow1);
    end
    for (int i = 0; i < 20; i++) begin
      a1 = W'($urandom); b1 = W'($urandom); cin1 = 1'($urandom); sub1 = 1'($urandom); in_valid1 = 1'b1;
      e = model(a1, b1, cin1, sub1);
      tick();
      n_vec++;
      if (out_valid1 !== 1'b1 || {overflow1, carry1, sum1} !== e) begin
        n_err++; $display("FAIL s1_random%0d: got v%0b %h want v1 %h", i, out_valid1, {overflow1, carry1, sum1}, e);
      end
    end
    in_valid1 = 1'b0;
    tick();
    n_vec++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL s1_bubble: got %0b want 0", out_valid1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_in_flight();
    test_single_stage();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port Rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port A, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port Cin, input, 1 bit, carry-in, used only when Sub=0.
REQ-008 The block SHALL have port Sub, input, 1 bit: 0 = add, 1 = subtract.
REQ-009 The block SHALL have port In_Valid, input, 1 bit, meaning operands are presented.
REQ-010 The block SHALL have port In_Ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-011 The block SHALL have port Sum, output, WIDTH bits, the result.
REQ-012 The block SHALL have port Carry, output, 1 bit, carry-out of the MSB.
REQ-013 The block SHALL have port Overflow, output, 1 bit, two's-complement signed overflow.
REQ-014 The block SHALL have port Out_Valid, output, 1 bit, meaning Sum, Carry and Overflow are valid.
REQ-015 The block SHALL have port Out_Ready, input, 1 bit, meaning the downstream consumer takes the result.

Function
REQ-016 The block SHALL define the slice width as SW = WIDTH/STAGES; stage k adds operand bits [k*SW +: SW] plus the carry registered by stage k-1.
REQ-017 For add, the result SHALL equal A + B + Cin; for subtract it SHALL equal A + ~B + 1, with Cin ignored.
REQ-018 The block SHALL truncate Sum to WIDTH bits and present bit WIDTH on Carry; for subtract, Carry=1 means no borrow.
REQ-019 Overflow SHALL be 1 when A[MSB] equals B_eff[MSB] and Sum[MSB] differs from them, where B_eff = B or ~B according to Sub.
REQ-020 Each stage SHALL carry a valid bit; operand slices not yet consumed and sum slices already produced SHALL be delayed so that all result bits emerge aligned.
REQ-021 The pipeline SHALL advance globally on Adv = ~Out_Valid | Out_Ready, and In_Ready SHALL equal Adv combinationally.
REQ-022 A transfer SHALL occur on In_Valid & In_Ready; with no stalls, the result SHALL appear with Out_Valid=1 exactly STAGES cycles after acceptance.
REQ-023 When Adv=0, every stage register, including valid bits, SHALL hold; Sum, Carry and Overflow SHALL stay stable while Out_Valid=1 and Out_Ready=0.
REQ-024 A bubble (In_Valid=0 while Adv=1) SHALL propagate as valid=0; results SHALL never be duplicated, dropped or reordered.
REQ-025 Simultaneous acceptance and output drain in the same cycle SHALL sustain a throughput of 1 result per cycle.
REQ-026 STAGES=1 SHALL degenerate to a single registered WIDTH-bit adder with latency 1.

Reset
REQ-027 While Rst_n=0, all valid bits, Sum, Carry and Overflow SHALL be 0 asynchronously, so Out_Valid=0 and In_Ready=1 after reset.
REQ-028 Transactions in flight at reset assertion SHALL be discarded; operation SHALL resume on the first rising edge after Rst_n deasserts.

Structure
REQ-029 A shared package pipelined_adder_pkg SHALL hold the default WIDTH/STAGES values and the SW derivation function or constant.
REQ-030 One sub-module, adder_slice, SHALL implement a combinational SW-bit ripple adder (sum and carry-out from A, B, Cin), instantiated STAGES times.
REQ-031 There SHALL be no combinational path from A, B, Cin or Sub to any output; the only combinational input-to-output path SHALL be Out_Ready to In_Ready.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-032 Add 0xFFFF+0x0001, Cin=0 -> 4 cycles later Sum=0x0000, Carry=1, Overflow=0.
REQ-033 Add 0x7FFF+0x0001 -> Sum=0x8000, Carry=0, Overflow=1.
REQ-034 Sub 0x0005-0x0007 -> Sum=0xFFFE, Carry=0, Overflow=0; Sub 0x8000-0x0001 -> Sum=0x7FFF, Carry=1, Overflow=1.
REQ-035 Stream 8 back-to-back operand pairs with Out_Ready=0 for 3 cycles mid-stream -> In_Ready=0 during the stall, outputs held, all 8 results correct and in order.
REQ-036 Assert Rst_n=0 with 3 transactions in flight -> Out_Valid=0 immediately, no stale results after release.
REQ-037 STAGES=1, add 0x00FF+0x0000 with Cin=1 -> Sum=0x0100 one cycle after acceptance.
